// File: rtl/updown_cnt_sequencer.sv
// Purpose: turns LOAD/UP/DOWN/HOLD commands into cycle-exact drive for a 16-bit up/down counter.
// Latency: all outputs registered; LOAD takes 1 active cycle, UP/DOWN/HOLD take N, then a 1-cycle done pulse.
// Backpressure: cmd_ready is high only in IDLE; a held cmd_valid waits there until the sequencer returns.
//
// Ports:
//   clk, rst_                  clock and asynchronous active-low reset
//   cmd_valid/cmd_ready        command handshake; cmd_op, cmd_data, cmd_steps are the command fields
//   abort                      cut the running COUNT/WAIT short
//   data_in, ld_cnt,
//   updn_cnt, count_enb        drive to the downstream counter (ld_cnt is active-low)
//   busy, done, aborted        status; aborted qualifies the done pulse
module updown_cnt_sequencer #(
   parameter int WIDTH = 16,
   parameter int STEPW = 8
) (
   input  logic             clk,
   input  logic             rst_,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic [STEPW-1:0] cmd_steps,
   input  logic             abort,
   output logic [WIDTH-1:0] data_in,
   output logic             ld_cnt,
   output logic             updn_cnt,
   output logic             count_enb,
   output logic             busy,
   output logic             done,
   output logic             aborted
);

   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_UP   = 2'b01;
   localparam logic [1:0] OP_DOWN = 2'b10;
   localparam logic [1:0] OP_HOLD = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_COUNT = 3'd2,
      S_WAIT  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t           state, state_nxt;
   logic [STEPW-1:0] rem, rem_nxt;
   logic [WIDTH-1:0] data_nxt;
   logic             updn_nxt;
   logic             aborted_nxt;
   logic             accept;

   assign accept = (state == S_IDLE) && cmd_valid && cmd_ready;

   always_comb begin
      state_nxt   = state;
      rem_nxt     = rem;
      data_nxt    = data_in;
      updn_nxt    = updn_cnt;
      aborted_nxt = 1'b0;
      case (state)
         S_IDLE: begin
            if (accept) begin
               case (cmd_op)
                  OP_LOAD: begin
                     state_nxt = S_LOAD;
                     data_nxt  = cmd_data;
                  end
                  OP_UP, OP_DOWN: begin
                     // Direction is taken at accept so it is already valid
                     // on the first enabled cycle.
                     updn_nxt  = (cmd_op == OP_UP);
                     rem_nxt   = cmd_steps;
                     state_nxt = (cmd_steps == '0) ? S_DONE : S_COUNT;
                  end
                  OP_HOLD: begin
                     rem_nxt   = cmd_steps;
                     state_nxt = (cmd_steps == '0) ? S_DONE : S_WAIT;
                  end
                  default: state_nxt = S_IDLE;
               endcase
            end
         end
         S_LOAD: state_nxt = S_DONE;
         S_COUNT, S_WAIT: begin
            rem_nxt = rem - 1'b1;
            if (rem == STEPW'(1)) begin
               // Final step edge: abort has nothing left to cut short.
               state_nxt = S_DONE;
            end else if (abort) begin
               state_nxt   = S_DONE;
               aborted_nxt = 1'b1;
               rem_nxt     = '0;
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Outputs are registered from the next state so each one lines up
   // exactly with the state it describes.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state     <= S_IDLE;
         rem       <= '0;
         data_in   <= '0;
         updn_cnt  <= 1'b1;
         ld_cnt    <= 1'b1;
         count_enb <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         aborted   <= 1'b0;
         cmd_ready <= 1'b0;
      end else begin
         state     <= state_nxt;
         rem       <= rem_nxt;
         data_in   <= data_nxt;
         updn_cnt  <= updn_nxt;
         ld_cnt    <= (state_nxt != S_LOAD);
         count_enb <= (state_nxt == S_COUNT);
         busy      <= (state_nxt == S_LOAD) || (state_nxt == S_COUNT) || (state_nxt == S_WAIT);
         done      <= (state_nxt == S_DONE);
         aborted   <= aborted_nxt;
         cmd_ready <= (state_nxt == S_IDLE);
      end
   end

endmodule

// File: tb/tb_updown_cnt_sequencer.sv
// Purpose: randomized scoreboard bench for updown_cnt_sequencer driving a behavioural 16-bit counter.
// Latency: expected done edge, counter value and status are predicted at accept time.
// Backpressure: the driver holds cmd_valid until cmd_ready, often back-to-back.
module tb_updown_cnt_sequencer;

   localparam int WIDTH = 16;
   localparam int STEPW = 8;

   logic             clk = 1'b0;
   logic             rst_;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [WIDTH-1:0] cmd_data;
   logic [STEPW-1:0] cmd_steps;
   logic             abort;
   logic [WIDTH-1:0] data_in;
   logic             ld_cnt;
   logic             updn_cnt;
   logic             count_enb;
   logic             busy;
   logic             done;
   logic             aborted;

   always #5 clk = ~clk;

   updown_cnt_sequencer #(.WIDTH(WIDTH), .STEPW(STEPW)) dut (
      .clk       (clk),
      .rst_      (rst_),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_data  (cmd_data),
      .cmd_steps (cmd_steps),
      .abort     (abort),
      .data_in   (data_in),
      .ld_cnt    (ld_cnt),
      .updn_cnt  (updn_cnt),
      .count_enb (count_enb),
      .busy      (busy),
      .done      (done),
      .aborted   (aborted)
   );

   // Downstream counter the sequencer is meant to drive.
   logic [WIDTH-1:0] cnt;
   always @(posedge clk or negedge rst_) begin
      if (!rst_)          cnt <= '0;
      else if (!ld_cnt)   cnt <= data_in;
      else if (count_enb) cnt <= updn_cnt ? cnt + 1'b1 : cnt - 1'b1;
   end

   int cyc = 0;
   always @(posedge clk) cyc++;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   typedef struct {
      int          edge_no;
      logic        ab;
      logic [15:0] cnt;
      logic [15:0] din;
      logic        dir;
      bit          dir_ok;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   // Reference state: counter value, last load value, last count direction.
   logic [15:0] m_cnt;
   logic [15:0] m_din;
   logic        m_dir;
   bit          m_dir_ok;

   always @(negedge clk) begin
      if (rst_ === 1'b1) begin
         if (count_enb) chk("busy_during_enable", busy, 1);
         if (done) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
            end else begin
               mon_e = sb.pop_front();
               chk("done_edge",       cyc,       mon_e.edge_no);
               chk("aborted",         aborted,   mon_e.ab);
               chk("counter_value",   cnt,       mon_e.cnt);
               chk("data_in_hold",    data_in,   mon_e.din);
               if (mon_e.dir_ok) chk("updn_hold", updn_cnt, mon_e.dir);
               chk("ready_in_done",   cmd_ready, 0);
               chk("busy_in_done",    busy,      0);
               chk("ld_cnt_in_done",  ld_cnt,    1);
               chk("enable_in_done",  count_enb, 0);
            end
         end
      end
   end

   // Called at a negedge. ab_k>0 drives abort so that it is sampled at
   // accept edge + ab_k; ab_acc raises abort together with the accepted command.
   task automatic issue(input logic [1:0] op, input logic [15:0] data, input logic [7:0] steps,
                        input int ab_k, input bit ab_acc, input int gap);
      exp_t e;
      int   waitc;
      int   act;
      cmd_op    = op;
      cmd_data  = data;
      cmd_steps = steps;
      cmd_valid = 1'b1;
      waitc     = 0;
      while (cmd_ready !== 1'b1 && waitc < 300) begin
         @(negedge clk);
         waitc++;
      end
      if (cmd_ready !== 1'b1) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout actual=no_ready required=ready (cycle %0d)", cyc);
         cmd_valid = 1'b0;
         return;
      end
      abort     = ab_acc;
      e.edge_no = cyc + 1;
      e.ab      = 1'b0;
      if (op == 2'd0) begin
         m_cnt     = data;
         m_din     = data;
         e.edge_no = e.edge_no + 1;
      end else begin
         act = int'(steps);
         if (ab_k >= 1 && ab_k < int'(steps)) begin
            act  = ab_k;
            e.ab = 1'b1;
         end
         e.edge_no = e.edge_no + act;
         if (op == 2'd1) m_cnt = m_cnt + 16'(act);
         if (op == 2'd2) m_cnt = m_cnt - 16'(act);
         if (op != 2'd3) begin
            if (steps != 0) begin
               m_dir    = (op == 2'd1);
               m_dir_ok = 1'b1;
            end else if (m_dir != (op == 2'd1)) begin
               m_dir_ok = 1'b0;
            end
         end
      end
      e.cnt    = m_cnt;
      e.din    = m_din;
      e.dir    = m_dir;
      e.dir_ok = m_dir_ok;
      sb.push_back(e);
      @(negedge clk);
      abort = 1'b0;
      if (ab_k > 0) begin
         cmd_valid = 1'b0;
         repeat (ab_k - 1) @(negedge clk);
         abort = 1'b1;
         @(negedge clk);
         abort = 1'b0;
      end
      if (gap > 0) begin
         cmd_valid = 1'b0;
         repeat (gap) @(negedge clk);
      end
   endtask

   task automatic drain();
      int w;
      w = 0;
      while (sb.size() != 0 && w < 400) begin
         @(negedge clk);
         w++;
      end
      chk("scoreboard_drained", sb.size(), 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "global timeout");
   end

   initial begin
      logic [1:0]  r_op;
      logic [7:0]  r_steps;
      int          r_k;
      rst_      = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = 2'd0;
      cmd_data  = '0;
      cmd_steps = '0;
      abort     = 1'b0;
      m_cnt     = 16'h0;
      m_din     = 16'h0;
      m_dir     = 1'b1;
      m_dir_ok  = 1'b1;

      repeat (3) @(negedge clk);
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_ld_cnt",    ld_cnt,    1);
      chk("rst_count_enb", count_enb, 0);
      chk("rst_updn_cnt",  updn_cnt,  1);
      chk("rst_data_in",   data_in,   0);
      chk("rst_busy",      busy,      0);
      chk("rst_done",      done,      0);
      chk("rst_aborted",   aborted,   0);
      rst_ = 1'b1;
      chk("ready_before_edge", cmd_ready, 0);
      @(negedge clk);
      chk("ready_after_release", cmd_ready, 1);

      // Directed cases.
      issue(2'd0, 16'd2, 8'd0, 0, 1'b0, 1);
      issue(2'd1, 16'h0, 8'd3, 0, 1'b0, 1);
      issue(2'd0, 16'd1, 8'd0, 0, 1'b0, 0);
      issue(2'd2, 16'h0, 8'd4, 0, 1'b0, 2);
      issue(2'd1, 16'h0, 8'd10, 4, 1'b0, 1);
      issue(2'd1, 16'h0, 8'd10, 10, 1'b0, 0);
      issue(2'd3, 16'h0, 8'd5, 0, 1'b0, 0);
      issue(2'd3, 16'h0, 8'd0, 0, 1'b0, 0);
      issue(2'd1, 16'h0, 8'd2, 0, 1'b1, 0);
      issue(2'd3, 16'h0, 8'd6, 3, 1'b0, 0);
      issue(2'd2, 16'h0, 8'd0, 1, 1'b0, 0);
      cmd_valid = 1'b0;
      drain();

      // Randomized commands, mostly back-to-back.
      for (int i = 0; i < 120; i++) begin
         r_op    = 2'($urandom_range(0, 3));
         r_steps = 8'($urandom_range(0, 14));
         r_k     = ($urandom_range(0, 2) == 0) ? $urandom_range(1, int'(r_steps) + 1) : 0;
         issue(r_op, 16'($urandom), r_steps, r_k, ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
      end
      cmd_valid = 1'b0;
      drain();

      // Reset in the middle of a count.
      issue(2'd1, 16'h0, 8'd8, 0, 1'b0, 0);
      cmd_valid = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_ = 1'b0;
      #1;
      chk("midrst_count_enb", count_enb, 0);
      chk("midrst_busy",      busy,      0);
      chk("midrst_ld_cnt",    ld_cnt,    1);
      chk("midrst_cmd_ready", cmd_ready, 0);
      chk("midrst_updn_cnt",  updn_cnt,  1);
      chk("midrst_counter",   cnt,       0);
      sb.delete();
      m_cnt    = 16'h0;
      m_din    = 16'h0;
      m_dir    = 1'b1;
      m_dir_ok = 1'b1;
      @(negedge clk);
      rst_ = 1'b1;
      chk("midrst_ready_before_edge", cmd_ready, 0);
      @(negedge clk);
      chk("midrst_ready_after_edge", cmd_ready, 1);
      repeat (12) @(negedge clk);

      issue(2'd1, 16'h0, 8'd2, 0, 1'b0, 0);
      cmd_valid = 1'b0;
      drain();
      repeat (3) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
